// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp bit positions, fault codes and lamp decode for the
// traffic lamp driver and its controller.
package traffic_pkg;

  localparam logic [1:0] NS_GREEN  = 2'd0;
  localparam logic [1:0] NS_YELLOW = 2'd1;
  localparam logic [1:0] EW_GREEN  = 2'd2;
  localparam logic [1:0] EW_YELLOW = 2'd3;

  localparam int RED = 2;
  localparam int YEL = 1;
  localparam int GRN = 0;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_STUCK   = 2'b10;

  typedef enum logic {RUN = 1'b0, FLASH = 1'b1} mode_t;

  // Returns {ns_lamp, ew_lamp}, each {red,yellow,green}.
  function automatic logic [5:0] lamp_decode(input logic [1:0] ph);
    logic [5:0] r;
    case (ph)
      NS_GREEN:  r = {3'b001, 3'b100};
      NS_YELLOW: r = {3'b010, 3'b100};
      EW_GREEN:  r = {3'b100, 3'b001};
      default:   r = {3'b100, 3'b010};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/traffic_lamp_driver_if.sv
// Controller-to-lamp-driver bundle. PED_WALK_EN adds the pedestrian outputs.
interface traffic_lamp_driver_if;
  import traffic_pkg::*;

  // No valid/ready pair: state is a level sampled on every clk edge, and
  // every driver output is a register updated on every edge.
  logic [1:0] state;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       fault;
  logic [1:0] fault_code;
  mode_t      dbg_mode;
`ifdef PED_WALK_EN
  logic       ped_walk;
  logic       ped_dont_walk;
`endif

  modport master (
    output state,
    input  ns_lamp, ew_lamp, fault, fault_code, dbg_mode
`ifdef PED_WALK_EN
    , input ped_walk, ped_dont_walk
`endif
  );

  modport slave (
    input  state,
    output ns_lamp, ew_lamp, fault, fault_code, dbg_mode
`ifdef PED_WALK_EN
    , output ped_walk, ped_dont_walk
`endif
  );

endinterface

// File: rtl/traffic_lamp_driver_blink_gen.sv
// Square-wave generator: BLINK_HALF cycles per half-period; restart makes the
// restarting edge count as the first on-cycle.
module blink_gen #(
  parameter int BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic on
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] cnt_q;
  logic          lvl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b1;
    end else if (restart) begin
      if (BLINK_HALF == 1) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= CW'(1);
        lvl_q <= 1'b1;
      end
    end else if (cnt_q == CW'(BLINK_HALF - 1)) begin
      cnt_q <= '0;
      lvl_q <= ~lvl_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign on = lvl_q;

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver with phase-sequence and stuck-phase checking, latching into a
// red-flash mode on the first fault. Optional macro: PED_WALK_EN.
module traffic_lamp_driver
  import traffic_pkg::*;
#(
  parameter int MAX_DWELL  = 16,
  parameter int BLINK_HALF = 4
) (
  input logic                  clk,
  input logic                  rst,
  traffic_lamp_driver_if.slave bus
);

  logic [1:0] phase_q;
  logic [4:0] dwell_q, dwell_d;
  mode_t      mode_q, mode_d;
  logic       fault_q, fault_d;
  logic [1:0] code_q, code_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic [5:0] dec;
  logic       hold, advance, illegal, stuck, fault_now, red_on;

  assign hold      = (bus.state == phase_q);
  assign advance   = (bus.state == phase_q + 2'd1);
  assign illegal   = !hold && !advance;
  assign stuck     = hold && (dwell_q == 5'(MAX_DWELL));
  assign fault_now = (mode_q == RUN) && (illegal || stuck);
  assign dec       = lamp_decode(bus.state);

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_red_blink (
    .clk(clk), .rst(rst), .restart(fault_now), .on(red_on)
  );

  always_comb begin
    mode_d  = mode_q;
    fault_d = fault_q;
    code_d  = code_q;
    ns_d    = dec[5:3];
    ew_d    = dec[2:0];
    // Dwell saturates so a long hold in FLASH cannot wrap it.
    if (advance)                 dwell_d = 5'd1;
    else if (hold && dwell_q != 5'd31) dwell_d = dwell_q + 5'd1;
    else                         dwell_d = dwell_q;
    case (mode_q)
      RUN: begin
        if (fault_now) begin
          mode_d  = FLASH;
          fault_d = 1'b1;
          code_d  = illegal ? FC_ILLEGAL : FC_STUCK;
          ns_d    = 3'b100;
          ew_d    = 3'b100;
        end
      end
      default: begin
        ns_d = {red_on, 2'b00};
        ew_d = {red_on, 2'b00};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= NS_GREEN;
      dwell_q <= '0;
      mode_q  <= RUN;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      ns_q    <= 3'b001;
      ew_q    <= 3'b100;
    end else begin
      phase_q <= bus.state;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign bus.ns_lamp    = ns_q;
  assign bus.ew_lamp    = ew_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.dbg_mode   = mode_q;

`ifdef PED_WALK_EN
  logic dw_on, walk_q, walk_d, dwk_q, dwk_d;

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_dw_blink (
    .clk(clk), .rst(rst),
    .restart(advance && bus.state == EW_YELLOW), .on(dw_on)
  );

  always_comb begin
    walk_d = 1'b0;
    dwk_d  = 1'b1;
    if (mode_q == RUN && !fault_now) begin
      case (bus.state)
        EW_GREEN:  begin walk_d = 1'b1; dwk_d = 1'b0; end
        EW_YELLOW: dwk_d = advance ? 1'b1 : dw_on;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      walk_q <= 1'b0;
      dwk_q  <= 1'b1;
    end else begin
      walk_q <= walk_d;
      dwk_q  <= dwk_d;
    end
  end

  assign bus.ped_walk      = walk_q;
  assign bus.ped_dont_walk = dwk_q;
`endif

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Directed bench for traffic_lamp_driver: vector table plus hand-written
// sequences for stuck, priority, reset-in-flash and optional PED_WALK_EN.
module tb_traffic_lamp_driver;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  traffic_lamp_driver_if bus ();

  traffic_lamp_driver #(.MAX_DWELL(16), .BLINK_HALF(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [1:0] st;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       f;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[19];
  logic [2:0] exp_ns_t[4];
  logic [2:0] exp_ew_t[4];

  task automatic step(input logic r, input logic [1:0] st);
    rst       = r;
    bus.state = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] ns, input logic [2:0] ew,
                     input logic f, input logic [1:0] code);
    total++;
    if ({bus.ns_lamp, bus.ew_lamp, bus.fault, bus.fault_code} !== {ns, ew, f, code}) begin
      bad++;
      $display("FAIL %s: got ns=%b ew=%b fault=%b code=%b, want ns=%b ew=%b fault=%b code=%b",
               name, bus.ns_lamp, bus.ew_lamp, bus.fault, bus.fault_code, ns, ew, f, code);
    end
  endtask

  task automatic chk_ped(input string name, input logic walk, input logic dwk);
`ifdef PED_WALK_EN
    total++;
    if ({bus.ped_walk, bus.ped_dont_walk} !== {walk, dwk}) begin
      bad++;
      $display("FAIL %s: got walk=%b dont_walk=%b, want walk=%b dont_walk=%b",
               name, bus.ped_walk, bus.ped_dont_walk, walk, dwk);
    end
`endif
  endtask

  initial begin
    bus.state = 2'd0;
    exp_ns_t = '{3'b001, 3'b010, 3'b100, 3'b100};
    exp_ew_t = '{3'b100, 3'b100, 3'b001, 3'b010};

    //          rst   st    ns      ew      f     code
    vecs[0]  = '{1'b1, 2'd0, 3'b001, 3'b100, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 2'd0, 3'b001, 3'b100, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 2'd1, 3'b010, 3'b100, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 2'd2, 3'b100, 3'b001, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 2'd3, 3'b100, 3'b010, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 2'd0, 3'b001, 3'b100, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 2'd2, 3'b100, 3'b100, 1'b1, 2'b01};
    vecs[7]  = '{1'b0, 2'd2, 3'b100, 3'b100, 1'b1, 2'b01};
    vecs[8]  = '{1'b0, 2'd3, 3'b100, 3'b100, 1'b1, 2'b01};
    vecs[9]  = '{1'b0, 2'd1, 3'b100, 3'b100, 1'b1, 2'b01};
    vecs[10] = '{1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 2'b01};
    vecs[11] = '{1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 2'b01};
    vecs[12] = '{1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 2'b01};
    vecs[13] = '{1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 2'b01};
    vecs[14] = '{1'b0, 2'd0, 3'b100, 3'b100, 1'b1, 2'b01};
    vecs[15] = '{1'b1, 2'd0, 3'b001, 3'b100, 1'b0, 2'b00};
    vecs[16] = '{1'b0, 2'd3, 3'b100, 3'b100, 1'b1, 2'b01};
    vecs[17] = '{1'b1, 2'd2, 3'b001, 3'b100, 1'b0, 2'b00};
    vecs[18] = '{1'b0, 2'd0, 3'b001, 3'b100, 1'b0, 2'b00};

    step(1'b1, 2'd0);
    step(1'b1, 2'd0);
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].r, vecs[i].st);
      chk($sformatf("vec%0d", i), vecs[i].ns, vecs[i].ew, vecs[i].f, vecs[i].code);
    end

    // Normal run: 10-cycle phases, two full rounds.
    step(1'b1, 2'd0);
    chk("run_reset", 3'b001, 3'b100, 1'b0, 2'b00);
    chk_ped("ped_reset", 1'b0, 1'b1);
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int ph = 0; ph < 4; ph++) begin
        for (int c = 0; c < 10; c++) begin
          step(1'b0, 2'(ph));
          chk($sformatf("run_r%0d_p%0d_c%0d", rnd, ph, c), exp_ns_t[ph], exp_ew_t[ph], 1'b0, 2'b00);
          chk_ped($sformatf("ped_r%0d_p%0d_c%0d", rnd, ph, c),
                  ph == 2, (ph == 3) ? (((c / 4) % 2) == 0) : (ph != 2));
        end
      end
    end

    // Stuck: 16 holds are fine, the 17th faults.
    step(1'b1, 2'd0);
    for (int c = 1; c <= 16; c++) begin
      step(1'b0, 2'd0);
      chk($sformatf("hold%0d", c), 3'b001, 3'b100, 1'b0, 2'b00);
    end
    step(1'b0, 2'd0);
    chk("stuck_edge", 3'b100, 3'b100, 1'b1, 2'b10);
    chk_ped("ped_flash", 1'b0, 1'b1);
    // Illegal jump while flashing: code stays frozen.
    step(1'b0, 2'd2);
    chk("flash_illegal_1", 3'b100, 3'b100, 1'b1, 2'b10);
    step(1'b0, 2'd0);
    chk("flash_2", 3'b100, 3'b100, 1'b1, 2'b10);
    step(1'b0, 2'd1);
    chk("flash_3", 3'b100, 3'b100, 1'b1, 2'b10);
    step(1'b0, 2'd3);
    chk("flash_off", 3'b000, 3'b000, 1'b1, 2'b10);
    step(1'b1, 2'd2);
    chk("rst_mid_flash", 3'b001, 3'b100, 1'b0, 2'b00);
    step(1'b0, 2'd0);
    chk("after_rst", 3'b001, 3'b100, 1'b0, 2'b00);

    // Priority: illegal 1->3 on the edge where dwell already equals 16.
    step(1'b1, 2'd0);
    step(1'b0, 2'd0);
    for (int c = 1; c <= 16; c++) begin
      step(1'b0, 2'd1);
      chk($sformatf("p1_hold%0d", c), 3'b010, 3'b100, 1'b0, 2'b00);
    end
    step(1'b0, 2'd3);
    chk("prio_illegal", 3'b100, 3'b100, 1'b1, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
